mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 64-bit data memory port between two requesters: instruction fetch (IF) and data load/store (D).
- Sequences each access through a small FSM: read wait, read-modify-write for sub-doubleword stores, single-cycle response pulse.
- Extracts and aligns bytes, and flags misaligned addresses so the control unit can take its trap path.
- Sits between the control unit/datapath registers and the memory model.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (legal 1..7).
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = D always wins.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  64  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_done  out  1  one-cycle pulse, fetch complete.
- if_rdata  out  32  instruction word.
- if_err  out  1  valid with if_done; misaligned fetch.
- d_req  in  1  data request.
- d_we  in  1  1 = store.
- d_size  in  2  0 = B, 1 = H, 2 = W, 3 = D.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data, right-aligned.
- d_gnt  out  1  data accepted this cycle.
- d_done  out  1  one-cycle pulse, access complete.
- d_rdata  out  64  load data, right-aligned, zero-extended.
- d_err  out  1  valid with d_done; misaligned access.
- mem_addr  out  64  doubleword address, bits [2:0] always 0.
- mem_wdata  out  64  write data.
- mem_wr  out  1  write enable.
- mem_rdata  in  64  read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: synchronous, active-high. Next edge forces IDLE and clears all registered outputs (rdata, err, mem_addr, mem_wdata, latched request) to 0.
- Reset mid-operation: aborts the access with no done pulse. mem_wr and both gnt are 0 in any cycle where Reset is high.
- RR pointer resets to "IF last", so the first tie goes to D.
- States: IDLE, RD, WR, RESP.
- Grant, IDLE only:
  - gnt is combinational from req, at most one per cycle.
  - One requester pending: grant it.
  - Both pending: RR_EN=1 grants the one not granted last; RR_EN=0 grants D.
  - Grant cycle T latches id, we, size, addr and wdata. The requester may drop req and change inputs after T.
- No grant in RD/WR/RESP; req is simply held pending.
- Alignment rules:
  - IF: misaligned if addr[1:0] != 0.
  - D: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
  - Misaligned: go IDLE -> RESP with no memory cycle; done and err at T+1, rdata = 0.
- Load or fetch:
  - RD for MEM_LAT cycles (T+1 .. T+MEM_LAT) with mem_addr = {addr[63:3], 3'b0}, mem_wr = 0.
  - Capture mem_rdata on the last RD edge, then RESP; done at T+MEM_LAT+1.
  - IF data = addr[2] ? rdata[63:32] : rdata[31:0].
  - D data = byte field at offset addr[2:0], zero-extended; sign extension belongs to the datapath.
- Store, size D: WR at T+1 (mem_wr = 1, mem_wdata = wdata), RESP at T+2.
- Store, size B/H/W (read-modify-write):
  - RD for MEM_LAT cycles.
  - Merge d_wdata low bytes into the read doubleword at offset addr[2:0]; the merged value is registered.
  - One WR cycle, then RESP; done at T+MEM_LAT+2.
- RESP: exactly one done pulse to the owning requester. Return to IDLE, where a new grant is possible in the same cycle.
- mem_addr is held between accesses; mem_wr = 1 only in WR.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum;
  - size codes SZ_B/SZ_H/SZ_W/SZ_D;
  - requester id enum REQ_IF/REQ_D;
  - a function returning the alignment mask per size.
- Sub-module byte_lane_merge (combinational) does load-field extract and store-data merge from size and offset.

Test Plan:
- Lone fetch, MEM_LAT=1, if_addr=0x104, memory dword 0x100 = 0xAABBCCDD_11223344 -> if_gnt at T, if_done at T+2, if_rdata=0xAABBCCDD, if_err=0.
- Simultaneous if_req and d_req (load D, addr 0x200) from reset -> D granted first, IF granted on the IDLE cycle after d_done, then alternating on repeated ties; with RR_EN=0, D always first.
- Byte store d_size=0, d_addr=0x203, d_wdata=0xFF, memory 0x200 = 0 -> one WR with mem_wdata=0x00000000_FF000000, d_done at T+3 (MEM_LAT=1).
- Misaligned W load at d_addr=0x202 -> d_done and d_err at T+1, mem_wr never asserted, d_rdata=0.
- Halfword load d_addr=0x206, dword = 0x8001_0000_0000_0000 -> d_rdata=0x0000_0000_0000_8001.
- Reset asserted during RD of a fetch -> no if_done, mem_wr stays 0, busy=0 after the edge, next request serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: types and helpers shared by the memory port arbiter.
//   state_t      arbiter FSM states
//   req_id_t     requester identity (instruction fetch or data access)
//   SZ_*         d_size encodings
//   align_mask() address bits that must be zero for an access of a given size
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } req_id_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the arbiter.
//   if_*   instruction fetch request/grant/response
//   d_*    data load/store request/grant/response
//   mem_*  doubleword memory port
//   busy   arbiter FSM not idle
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        d_err;

  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, if_err,
    output d_gnt, d_done, d_rdata, d_err,
    output mem_addr, mem_wdata, mem_wr, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, if_err,
    input  d_gnt, d_done, d_rdata, d_err,
    input  mem_addr, mem_wdata, mem_wr, busy
  );
endinterface

// File: rtl/mem_port_arbiter_byte_lane_merge.sv
// byte_lane_merge: combinational byte-lane handling for sub-doubleword accesses.
//   size, offset  access size code and byte offset within the doubleword
//   dword         doubleword read from memory
//   wdata         right-aligned store data
//   load_data     field at offset, right-aligned, zero-extended
//   merged        dword with the store field replaced by wdata's low bytes
module byte_lane_merge
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] dword,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] field_mask;
  logic [63:0] lane_mask;

  always_comb begin
    shamt = {offset, 3'b000};
    case (size)
      SZ_B:    field_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    field_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    field_mask = 64'h0000_0000_FFFF_FFFF;
      default: field_mask = '1;
    endcase
    lane_mask = field_mask << shamt;
    load_data = (dword >> shamt) & field_mask;
    merged    = (dword & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit data memory port between instruction
// fetch and data load/store. Grants in IDLE, waits MEM_LAT cycles on reads,
// does read-modify-write for B/H/W stores, and pulses done for one cycle.
// Misaligned requests skip the memory and complete with err set.
//   Clk, Reset  clock, synchronous active-high reset
//   bus         mem_port_arbiter_if slave modport (requesters + memory)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned RR_EN   = 1
) (
  input logic              Clk,
  input logic              Reset,
  mem_port_arbiter_if.slave bus
);

  state_t      state, state_nxt;
  req_id_t     owner, rr_last;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic [2:0]  lat_off;
  logic [63:0] lat_wdata;
  logic [2:0]  lat_cnt;
  logic [63:0] mem_addr_q, mem_wdata_q, d_rdata_q;
  logic [31:0] if_rdata_q;
  logic        err_q;

  logic        gnt_if, gnt_d, gnt_any;
  logic [63:0] g_addr;
  logic [1:0]  g_size;
  logic        g_we, g_mis;
  logic [63:0] load_data, merged;

  byte_lane_merge u_lane (
    .size      (lat_size),
    .offset    (lat_off),
    .dword     (bus.mem_rdata),
    .wdata     (lat_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // Arbitration and the view of the request being granted this cycle.
  // Fetches are checked with the word mask, which is exactly addr[1:0] == 0.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (state == ST_IDLE && !Reset) begin
      if (bus.if_req && bus.d_req) begin
        if (RR_EN != 0 && rr_last == REQ_D) gnt_if = 1'b1;
        else                                 gnt_d  = 1'b1;
      end else if (bus.d_req) begin
        gnt_d = 1'b1;
      end else if (bus.if_req) begin
        gnt_if = 1'b1;
      end
    end
    gnt_any = gnt_if | gnt_d;
    g_addr  = gnt_d ? bus.d_addr : bus.if_addr;
    g_size  = gnt_d ? bus.d_size : SZ_W;
    g_we    = gnt_d & bus.d_we;
    g_mis   = |(g_addr[2:0] & align_mask(g_size));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_any) begin
          if (g_mis)                        state_nxt = ST_RESP;
          else if (g_we && g_size == SZ_D)  state_nxt = ST_WR;
          else                              state_nxt = ST_RD;
        end
      end
      ST_RD:   if (lat_cnt == '0) state_nxt = lat_we ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner       <= REQ_IF;
      rr_last     <= REQ_IF;
      lat_we      <= 1'b0;
      lat_size    <= '0;
      lat_off     <= '0;
      lat_wdata   <= '0;
      lat_cnt     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      d_rdata_q   <= '0;
      if_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            owner     <= gnt_d ? REQ_D : REQ_IF;
            rr_last   <= gnt_d ? REQ_D : REQ_IF;
            lat_we    <= g_we;
            lat_size  <= g_size;
            lat_off   <= g_addr[2:0];
            lat_wdata <= bus.d_wdata;
            lat_cnt   <= 3'(MEM_LAT - 1);
            err_q     <= g_mis;
            if (g_mis) begin
              if (gnt_d) d_rdata_q  <= '0;
              else       if_rdata_q <= '0;
            end else begin
              mem_addr_q <= {g_addr[63:3], 3'b000};
              if (g_we && g_size == SZ_D) mem_wdata_q <= bus.d_wdata;
            end
          end
        end
        ST_RD: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else if (lat_we) begin
            mem_wdata_q <= merged;
          end else if (owner == REQ_IF) begin
            if_rdata_q <= lat_off[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
          end else begin
            d_rdata_q <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.if_done   = (state == ST_RESP) && !Reset && (owner == REQ_IF);
  assign bus.d_done    = (state == ST_RESP) && !Reset && (owner == REQ_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_err    = err_q && (owner == REQ_IF);
  assign bus.d_err     = err_q && (owner == REQ_D);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = (state == ST_WR) && !Reset;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants push expected responses,
// done pulses pop and compare them. A second instance covers fixed priority.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus2 ();

  mem_port_arbiter #(.MEM_LAT(1), .RR_EN(1)) u_dut (.Clk(clk), .Reset(rst), .bus(bus));
  mem_port_arbiter #(.MEM_LAT(2), .RR_EN(0)) u_fix (.Clk(clk), .Reset(rst), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;
  logic [63:0] last_wr_data = '0;
  logic [63:0] last_wr_addr = '0;
  logic [63:0] mem [0:127];

  typedef struct {
    bit          is_d;
    logic [63:0] rdata;
    bit          chk_data;
    bit          err;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  bit   gnt_log[$];
  int   gnt_cyc[$];

  assign bus.mem_rdata  = mem[bus.mem_addr[9:3]];
  assign bus2.mem_rdata = {bus2.mem_addr[63:3], 3'b000};

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_wr) begin
      wr_cnt = wr_cnt + 1;
      last_wr_data = bus.mem_wdata;
      last_wr_addr = bus.mem_addr;
      mem[bus.mem_addr[9:3]] = bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.if_done || bus.d_done) begin
      if (sb.size() == 0) begin
        check("unexp_done", {62'd0, bus.if_done, bus.d_done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_both", 64'(bus.if_done & bus.d_done), 64'd0);
        check("done_who", 64'(bus.d_done), 64'(e.is_d));
        check("done_cyc", 64'(cyc), 64'(e.done_cyc));
        if (e.is_d) begin
          check("d_err", 64'(bus.d_err), 64'(e.err));
          if (e.chk_data) check("d_rdata", bus.d_rdata, e.rdata);
        end else begin
          check("if_err", 64'(bus.if_err), 64'(e.err));
          check("if_rdata", 64'(bus.if_rdata), e.rdata);
        end
      end
    end
  end

  task automatic run_d(input logic we, input logic [1:0] size, input logic [63:0] addr,
                       input logic [63:0] wdata, input bit chk, input logic [63:0] exp_data,
                       input bit exp_err, input int lat);
    bit   got = 1'b0;
    exp_t e;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size; bus.d_addr = addr; bus.d_wdata = wdata;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.d_gnt) begin
        got = 1'b1;
        e.is_d = 1'b1; e.rdata = exp_data; e.chk_data = chk; e.err = exp_err;
        e.done_cyc = cyc + lat;
        sb.push_back(e);
        gnt_log.push_back(1'b1);
        gnt_cyc.push_back(cyc);
      end
    end
    check("d_gnt_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_we = ~we; bus.d_size = ~size;
    bus.d_addr = 64'hFFFF_FFFF_FFFF_FFFF; bus.d_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic run_if(input logic [63:0] addr, input logic [31:0] exp_data,
                        input bit exp_err, input int lat);
    bit   got = 1'b0;
    exp_t e;
    bus.if_req = 1'b1; bus.if_addr = addr;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.if_gnt) begin
        got = 1'b1;
        e.is_d = 1'b0; e.rdata = 64'(exp_data); e.chk_data = 1'b1; e.err = exp_err;
        e.done_cyc = cyc + lat;
        sb.push_back(e);
        gnt_log.push_back(1'b0);
        gnt_cyc.push_back(cyc);
      end
    end
    check("if_gnt_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_addr = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
    check("rst_d_gnt", 64'(bus.d_gnt), 64'd0);
    check("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_d_rdata", bus.d_rdata, 64'd0);
    check("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int w0;
    int if_cnt;
    int d_cnt;
    bit got;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[7'h20] = 64'hAABBCCDD_11223344;
    mem[7'h40] = 64'h01234567_89ABCDEF;
    bus.if_addr = '0; bus.d_we = 1'b0; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    bus2.d_size = SZ_D; bus2.d_addr = '0; bus2.d_wdata = '0;

    do_reset();
    run_if(64'h104, 32'hAABBCCDD, 1'b0, 2);
    wait_drain();

    // Tie from reset: D first, IF on the IDLE cycle after d_done.
    do_reset();
    base = gnt_log.size();
    fork
      run_d(1'b0, SZ_D, 64'h200, 64'd0, 1'b1, 64'h01234567_89ABCDEF, 1'b0, 2);
      run_if(64'h100, 32'h11223344, 1'b0, 2);
    join
    wait_drain();
    check("tie1_first_d", 64'(gnt_log[base]), 64'd1);
    check("tie1_second_if", 64'(gnt_log[base+1]), 64'd0);
    check("tie1_if_gap", 64'(gnt_cyc[base+1] - gnt_cyc[base]), 64'd3);

    // After a lone D, the next tie goes to IF.
    run_d(1'b0, SZ_W, 64'h204, 64'd0, 1'b1, 64'h0000_0000_0123_4567, 1'b0, 2);
    wait_drain();
    base = gnt_log.size();
    fork
      run_d(1'b0, SZ_B, 64'h201, 64'd0, 1'b1, 64'h0000_0000_0000_00CD, 1'b0, 2);
      run_if(64'h104, 32'hAABBCCDD, 1'b0, 2);
    join
    wait_drain();
    check("tie2_first_if", 64'(gnt_log[base]), 64'd0);
    check("tie2_second_d", 64'(gnt_log[base+1]), 64'd1);

    // Byte store RMW.
    mem[7'h40] = '0;
    w0 = wr_cnt;
    run_d(1'b1, SZ_B, 64'h203, 64'hFF, 1'b0, 64'd0, 1'b0, 3);
    wait_drain();
    check("bst_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("bst_wdata", last_wr_data, 64'h00000000_FF000000);
    check("bst_waddr", last_wr_addr, 64'h200);

    // Halfword store keeps the surrounding bytes.
    mem[7'h41] = 64'h11111111_11111111;
    run_d(1'b1, SZ_H, 64'h20A, 64'h1234_BEEF, 1'b0, 64'd0, 1'b0, 3);
    wait_drain();
    check("hst_mem", mem[7'h41], 64'h11111111_BEEF1111);
    run_d(1'b0, SZ_B, 64'h20B, 64'd0, 1'b1, 64'h0000_0000_0000_00BE, 1'b0, 2);
    wait_drain();

    // Dword store: single WR cycle.
    w0 = wr_cnt;
    run_d(1'b1, SZ_D, 64'h300, 64'hCAFEF00D_12345678, 1'b0, 64'd0, 1'b0, 2);
    wait_drain();
    check("dst_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("dst_mem", mem[7'h60], 64'hCAFEF00D_12345678);

    // Misaligned accesses: no memory cycle, err with rdata 0.
    w0 = wr_cnt;
    run_d(1'b0, SZ_W, 64'h202, 64'd0, 1'b1, 64'd0, 1'b1, 1);
    wait_drain();
    run_d(1'b1, SZ_H, 64'h205, 64'hFFFF, 1'b0, 64'd0, 1'b1, 1);
    wait_drain();
    run_if(64'h102, 32'd0, 1'b1, 1);
    wait_drain();
    check("mis_no_wr", 64'(wr_cnt - w0), 64'd0);

    // Halfword load, zero-extended.
    mem[7'h40] = 64'h8001_0000_0000_0000;
    run_d(1'b0, SZ_H, 64'h206, 64'd0, 1'b1, 64'h0000_0000_0000_8001, 1'b0, 2);
    wait_drain();

    // Reset during RD of a fetch aborts it silently.
    w0 = wr_cnt;
    bus.if_req = 1'b1; bus.if_addr = 64'h104;
    @(negedge clk);
    check("abort_gnt", 64'(bus.if_gnt), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    check("abort_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("abort_if_gnt", 64'(bus.if_gnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_no_wr", 64'(wr_cnt - w0), 64'd0);
    @(posedge clk); #1;
    run_if(64'h104, 32'hAABBCCDD, 1'b0, 2);
    wait_drain();

    // Fixed priority instance: D wins every tie while it keeps requesting.
    bus2.if_req = 1'b1; bus2.d_req = 1'b1;
    if_cnt = 0; d_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus2.if_gnt) if_cnt++;
      if (bus2.d_gnt) d_cnt++;
    end
    check("fix_if_gnts", 64'(if_cnt), 64'd0);
    check("fix_d_gnts", 64'(d_cnt), 64'd5);
    @(posedge clk); #1;
    bus2.d_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus2.if_gnt) got = 1'b1;
    end
    check("fix_if_after", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus2.if_req = 1'b0;
    repeat (6) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
